lfsr_stream_checker: RTL and testbench

- Sits directly downstream of the 8-bit Fibonacci LFSR generator and consumes its `data` output one beat at a time.
- Self-synchronises to the incoming pseudo-random sequence, declares lock, then flags and counts every beat that deviates from the predicted sequence.
- Drops lock after a run of consecutive errors.
- Used as the link/datapath integrity monitor in loopback and BIST configurations.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/lfsr_stream_checker.sv | 105 ++++++++++
 tb/tb_lfsr_stream_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR generator and its stream checker.
// The step function lives here so the generator and the checker share one polynomial.
package lfsr_pkg;

    localparam int              LFSR_W       = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'hD2;
    localparam logic [LFSR_W-1:0] LFSR_SEED    = 8'h8A;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // New MSB is the parity of the tapped bits; the register shifts right.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] x,
        input logic [LFSR_W-1:0] taps
    );
        return {^(x & taps), x[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising integrity checker for an LFSR data stream: seeds from the
// stream, confirms lock, then counts every deviating beat until lock is lost.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS       = DEFAULT_TAPS,
    parameter int                LOCK_CNT   = 4,
    parameter int                UNLOCK_CNT = 3,
    parameter int                ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              err_clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        state_o
);

    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

    chk_state_t        state;
    logic [LFSR_W-1:0] pred;
    logic [3:0]        match_cnt;
    logic [3:0]        bad_run;

    assign state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            pred      <= '0;
            match_cnt <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (err_clear) begin
                err_cnt <= '0;
            end

            if (data_valid) begin
                case (state)
                    SEARCH: begin
                        // 0x00 is the LFSR lock-up value and can never seed a sequence.
                        if (data_in != '0) begin
                            pred      <= lfsr_next(data_in, TAPS);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end

                    VERIFY: begin
                        if (data_in == pred) begin
                            pred      <= lfsr_next(data_in, TAPS);
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt == LOCK_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                bad_run <= '0;
                            end
                        end else if (data_in != '0) begin
                            pred      <= lfsr_next(data_in, TAPS);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end

                    LOCKED: begin
                        // Free-running prediction: a corrupted beat never disturbs the phase.
                        pred <= lfsr_next(pred, TAPS);
                        if (data_in == pred) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (!err_clear && (err_cnt != '1)) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (bad_run == UNLOCK_LAST) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                bad_run   <= '0;
                            end else begin
                                bad_run <= bad_run + 4'd1;
                            end
                        end
                    end

                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: a behavioural model predicts outputs
// per beat, a monitor pops and compares them after each clock edge.
module tb_lfsr_stream_checker;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;
    localparam int EW     = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          err_clear = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_cnt;
    logic [1:0]    state_o;

    lfsr_stream_checker #(
        .TAPS(8'hD2), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .ERR_W(EW)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .err_clear(err_clear), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lk;
        logic       pulse;
        logic [3:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: phase 0=hunting, 1=confirming, 2=locked.
    int         m_phase;
    logic [7:0] m_pred;
    int         m_good;
    int         m_bad;
    int         m_cnt;
    logic       m_pulse;
    logic [7:0] gen;

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        int ones;
        logic [31:0] p;
        ones = $countones(x & 8'hD2);
        p = 32'(ones % 2);
        return {p[0], x[7:1]};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pred = 8'h00; m_good = 0; m_bad = 0; m_cnt = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
        m_pulse = 1'b0;
        if (v) begin
            if (m_phase == 0) begin
                if (d != 8'h00) begin m_pred = ref_next(d); m_good = 0; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (d == m_pred) begin
                    m_pred = ref_next(d);
                    m_good++;
                    if (m_good >= LOCK) begin m_phase = 2; m_bad = 0; end
                end else if (d != 8'h00) begin
                    m_pred = ref_next(d); m_good = 0;
                end else begin
                    m_phase = 0;
                end
            end else begin
                if (d == m_pred) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_cnt < (1 << EW) - 1) m_cnt++;
                    m_bad++;
                    if (m_bad >= UNLOCK) begin m_phase = 0; m_good = 0; m_bad = 0; end
                end
                m_pred = ref_next(m_pred);
            end
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.lk    = (m_phase == 2);
        e.pulse = m_pulse;
        e.cnt   = 4'(m_cnt);
        e.st    = 2'(m_phase);
        q.push_back(e);
    endtask

    task automatic beat(input logic v, input logic [7:0] d, input logic clr);
        @(negedge clk);
        reset = 1'b0; data_valid = v; data_in = d; err_clear = clr;
        model_step(v, d, clr);
        push_expect();
    endtask

    task automatic clean();
        beat(1'b1, gen, 1'b0);
        gen = ref_next(gen);
    endtask

    task automatic corrupt(input logic [7:0] mask, input logic clr);
        beat(1'b1, gen ^ mask, clr);
        gen = ref_next(gen);
    endtask

    task automatic gap();
        logic [7:0] junk;
        junk = 8'($urandom);
        beat(1'b0, junk, 1'b0);
    endtask

    // Waits until the beat just driven has been sampled and its outputs are visible.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1; data_valid = 1'b0; err_clear = 1'b0;
        model_reset();
        #1;
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_state"}, int'(state_o), 0);
        check({tag, "_pulse"}, int'(err_pulse), 0);
        push_expect();
    endtask

    // Monitor: every clock edge the DUT presents a fresh output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("mon_locked", int'(locked), int'(e.lk));
                check("mon_err_pulse", int'(err_pulse), int'(e.pulse));
                check("mon_err_cnt", int'(err_cnt), int'(e.cnt));
                check("mon_state", int'(state_o), int'(e.st));
            end
        end
    end

    initial begin
        logic [7:0] mask;
        int         r;
        model_reset();
        gen = 8'h8A;
        async_reset("init_reset");

        // Zero beats never seed
        for (int i = 0; i < 5; i++) beat(1'b1, 8'h00, 1'b0);
        settle();
        check("zero_state", int'(state_o), 0);
        check("zero_locked", int'(locked), 0);

        // Lock acquisition from 0x8A
        clean();
        settle();
        check("acq_verify_state", int'(state_o), 1);
        for (int i = 0; i < 3; i++) clean();
        settle();
        check("acq_not_yet_locked", int'(locked), 0);
        clean();
        settle();
        check("acq_locked", int'(locked), 1);
        check("acq_err_cnt", int'(err_cnt), 0);
        for (int i = 0; i < 3; i++) clean();

        // Single error
        corrupt(8'h01, 1'b0);
        settle();
        check("single_pulse", int'(err_pulse), 1);
        check("single_cnt", int'(err_cnt), 1);
        clean();
        settle();
        check("single_no_repeat", int'(err_pulse), 0);
        check("single_still_locked", int'(locked), 1);

        // Loss of lock then re-lock
        for (int i = 0; i < 3; i++) corrupt(8'h5A, 1'b0);
        settle();
        check("unlock_cnt", int'(err_cnt), 4);
        check("unlock_locked", int'(locked), 0);
        for (int i = 0; i < 5; i++) clean();
        settle();
        check("relock", int'(locked), 1);
        check("relock_cnt_kept", int'(err_cnt), 4);

        // Gaps mid-stream
        for (int i = 0; i < 7; i++) gap();
        for (int i = 0; i < 4; i++) clean();
        settle();
        check("gap_locked", int'(locked), 1);
        check("gap_no_err", int'(err_cnt), 4);

        // Saturation with isolated errors
        for (int i = 0; i < 20; i++) begin
            corrupt(8'h80, 1'b0);
            clean();
            clean();
        end
        settle();
        check("sat_cnt", int'(err_cnt), 15);
        corrupt(8'h10, 1'b1);
        settle();
        check("clear_cnt", int'(err_cnt), 0);
        check("clear_pulse", int'(err_pulse), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                gap();
            end else if (r < 30) begin
                mask = 8'($urandom_range(1, 255));
                corrupt(mask, 1'b0);
            end else if (r < 33) begin
                beat(1'b1, 8'h00, 1'b0);
                gen = ref_next(gen);
            end else begin
                beat(1'b1, gen, r >= 97 ? 1'b1 : 1'b0);
                gen = ref_next(gen);
            end
        end

        // Reach lock, then reset asynchronously
        for (int i = 0; i < 8; i++) clean();
        corrupt(8'h02, 1'b0);
        settle();
        check("pre_reset_locked", int'(locked), 1);
        async_reset("mid_reset");
        for (int i = 0; i < 6; i++) clean();

        settle();
        #10;
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
